exec_multi: RTL

Parametrised execute stage for the multi-issue pipeline, sitting between register read/forwarding and the memory stage. It executes LANES independent instruction slots per bundle, adds logic/compare ops, and adds an iterative multi-cycle multiply that stalls the whole bundle while it runs. Bubbles are inserted on stall/interlock exactly as in the current two-lane stage, so downstream stages are unchanged apart from width.

---
 rtl/exec_multi_pkg.sv | 22 ++
 rtl/exec_multi_if.sv | 36 +++
 rtl/exec_mul_iter.sv | 42 ++++
 rtl/exec_multi.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/exec_multi_pkg.sv
// exec_pkg: op codes and shared constants for the multi-issue execute stage.
// Rev 1.0
`default_nettype none
package exec_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SRA  = 4'd3,
    OP_SLL  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } exec_type_e;

  localparam logic [5:0] LOAD_OPCODE   = 6'b010000;
  localparam logic [2:0] BUBBLE_PREFIX = 3'b111;
endpackage
`default_nettype wire

// File: rtl/exec_multi_if.sv
// exec_multi_if: bundle-level bus between register read and the execute stage.
// Rev 1.0
`default_nettype none
interface exec_multi_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int IW    = 32
);
  logic                    interlock;
  logic                    exec_stall;
  logic [LANES*IW-1:0]     inst;
  logic [LANES*XLEN-1:0]   srca;
  logic [LANES*XLEN-1:0]   srcb;
  logic [LANES*4-1:0]      e_type;
  logic [LANES*5-1:0]      rt;
  logic [LANES-1:0]        rt_flag;
  logic                    exec_busy;
  logic [LANES-1:0]        ex_to_mem_ready;
  logic [LANES*IW-1:0]     inst_to_the_next;
  logic [LANES*XLEN-1:0]   tdata;
  logic [LANES*5-1:0]      rt_to_the_next;
  logic [LANES-1:0]        rt_flag_to_the_next;

  modport master (
    output interlock, exec_stall, inst, srca, srcb, e_type, rt, rt_flag,
    input  exec_busy, ex_to_mem_ready, inst_to_the_next, tdata,
           rt_to_the_next, rt_flag_to_the_next
  );

  modport slave (
    input  interlock, exec_stall, inst, srca, srcb, e_type, rt, rt_flag,
    output exec_busy, ex_to_mem_ready, inst_to_the_next, tdata,
           rt_to_the_next, rt_flag_to_the_next
  );
endinterface
`default_nettype wire

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier, one XLEN/MUL_CYCLES-bit digit per step.
// Rev 1.0
`default_nettype none
module exec_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_product
);
  localparam int K = XLEN / MUL_CYCLES;

  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_first_digit;
  logic [XLEN-1:0] w_digit;

  assign w_first_digit = XLEN'(i_b[K-1:0]);
  assign w_digit       = XLEN'(r_mplier[K-1:0]);

  // The start edge already folds in the lowest digit, so the product is
  // complete after MUL_CYCLES-1 further steps.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc    <= i_a * w_first_digit;
      r_mcand  <= i_a << K;
      r_mplier <= i_b >> K;
    end else if (i_step) begin
      r_acc    <= r_acc + r_mcand * w_digit;
      r_mcand  <= r_mcand << K;
      r_mplier <= r_mplier >> K;
    end
  end

  assign o_product = r_acc;
endmodule
`default_nettype wire

// File: rtl/exec_multi.sv
// exec_multi: LANES-wide execute stage with single-cycle ALU ops and a bundle-stalling iterative multiply.
// Rev 1.0
`default_nettype none
module exec_multi
  import exec_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int XLEN       = 32,
  parameter int IW         = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  exec_multi_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam logic [IW-1:0] BUBBLE_INST = {BUBBLE_PREFIX, {(IW-3){1'b0}}};

  generate
    if (XLEN % MUL_CYCLES != 0) begin : g_bad_cfg
      $error("exec_multi: XLEN must be a multiple of MUL_CYCLES");
    end
  endgenerate

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_SRA:  alu = $unsigned($signed(a) >>> sh);
      OP_SLL:  alu = a << sh;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLT:  alu = XLEN'($signed(a) < $signed(b));
      OP_SLTU: alu = XLEN'(a < b);
      default: alu = b;
    endcase
  endfunction

  logic [0:0]      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_cnt_last, w_any_mul, w_fire, w_start, w_step;
  logic [LANES-1:0] w_in_mul;

  logic [IW-1:0]   r_h_inst [LANES];
  logic [XLEN-1:0] r_h_a    [LANES];
  logic [XLEN-1:0] r_h_b    [LANES];
  logic [3:0]      r_h_type [LANES];
  logic [4:0]      r_h_rt   [LANES];
  logic [LANES-1:0] r_h_rtf;

  logic [IW-1:0]   w_inst [LANES];
  logic [3:0]      w_type [LANES];
  logic [4:0]      w_rt   [LANES];
  logic [LANES-1:0] w_rtf;
  logic [XLEN-1:0] w_res  [LANES];
  logic [XLEN-1:0] w_prod [LANES];

  logic [LANES*IW-1:0]   r_inst_o;
  logic [LANES*XLEN-1:0] r_tdata;
  logic [LANES*5-1:0]    r_rt_o;
  logic [LANES-1:0]      r_rtf_o;
  logic [LANES-1:0]      r_rdy;

  // While multiplying, every lane reads from the hold registers so the
  // non-Mul lanes retire alongside the product.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [XLEN-1:0] w_a, w_b;
      assign w_in_mul[gi] = (bus.e_type[gi*4 +: 4] == OP_MUL);
      assign w_inst[gi]   = (r_state == S_MUL) ? r_h_inst[gi] : bus.inst[gi*IW +: IW];
      assign w_a          = (r_state == S_MUL) ? r_h_a[gi]    : bus.srca[gi*XLEN +: XLEN];
      assign w_b          = (r_state == S_MUL) ? r_h_b[gi]    : bus.srcb[gi*XLEN +: XLEN];
      assign w_type[gi]   = (r_state == S_MUL) ? r_h_type[gi] : bus.e_type[gi*4 +: 4];
      assign w_rt[gi]     = (r_state == S_MUL) ? r_h_rt[gi]   : bus.rt[gi*5 +: 5];
      assign w_rtf[gi]    = (r_state == S_MUL) ? r_h_rtf[gi]  : bus.rt_flag[gi];
      assign w_res[gi]    = (w_type[gi] == OP_MUL) ? w_prod[gi] : alu(w_type[gi], w_a, w_b);

      exec_mul_iter #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk       (clk),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_a       (bus.srca[gi*XLEN +: XLEN]),
        .i_b       (bus.srcb[gi*XLEN +: XLEN]),
        .o_product (w_prod[gi])
      );
    end
  endgenerate

  assign w_any_mul  = |w_in_mul;
  assign w_cnt_last = (r_cnt == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!bus.interlock && !bus.exec_stall && w_any_mul) begin
          w_state_nxt = S_MUL;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (!bus.exec_stall) begin
          if (w_cnt_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    w_fire  = 1'b0;
    w_start = 1'b0;
    w_step  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.interlock && !bus.exec_stall) begin
          w_start = w_any_mul;
          w_fire  = !w_any_mul;
        end
      end
      default: begin
        if (!bus.exec_stall) begin
          w_fire = w_cnt_last;
          w_step = !w_cnt_last;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      for (int i = 0; i < LANES; i++) begin
        r_h_inst[i] <= bus.inst[i*IW +: IW];
        r_h_a[i]    <= bus.srca[i*XLEN +: XLEN];
        r_h_b[i]    <= bus.srcb[i*XLEN +: XLEN];
        r_h_type[i] <= bus.e_type[i*4 +: 4];
        r_h_rt[i]   <= bus.rt[i*5 +: 5];
      end
      r_h_rtf <= bus.rt_flag;
    end
  end

  // On a bubble tdata and rt_to_the_next keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_o <= {LANES{BUBBLE_INST}};
      r_tdata  <= '0;
      r_rt_o   <= '0;
      r_rtf_o  <= '0;
      r_rdy    <= '0;
    end else if (w_fire) begin
      for (int i = 0; i < LANES; i++) begin
        r_inst_o[i*IW +: IW]     <= w_inst[i];
        r_tdata[i*XLEN +: XLEN]  <= w_res[i];
        r_rt_o[i*5 +: 5]         <= w_rt[i];
        r_rdy[i]                 <= (w_inst[i][IW-1 -: 6] == LOAD_OPCODE);
      end
      r_rtf_o <= w_rtf;
    end else begin
      r_inst_o <= {LANES{BUBBLE_INST}};
      r_rtf_o  <= '0;
      r_rdy    <= '0;
    end
  end

  assign bus.exec_busy           = (r_state == S_MUL);
  assign bus.ex_to_mem_ready     = r_rdy;
  assign bus.inst_to_the_next    = r_inst_o;
  assign bus.tdata               = r_tdata;
  assign bus.rt_to_the_next      = r_rt_o;
  assign bus.rt_flag_to_the_next = r_rtf_o;
endmodule
`default_nettype wire
